// File: rtl/approx_term_unit.sv
// approx_term_unit: decides when the series approximation has converged, raises the
//   stop request to the controller and holds the final result for the next stage.
// Latency: valid_o is combinational in the check cycle; result_valid_o follows one cycle later.
// Backpressure: the result is held in HOLD until result_ready_i; start_i and check_i are ignored there.
// Ports: clk/rst (sync, active-high); start_i, check_i, y_i from the controller/datapath;
//   valid_o stop request; result_o/iter_o/timeout_o with result_valid_o/result_ready_i handshake.
// Option: define TERM_ITER_LIMIT_EN to stop after MAX_ITER checks and report timeout_o.
module approx_term_unit #(
  parameter int WIDTH    = 16,
  parameter int ITER_W   = 6,
  parameter int EPS      = 8,
  parameter int MAX_ITER = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              check_i,
  input  logic [WIDTH-1:0]  y_i,
  output logic              valid_o,
  output logic [WIDTH-1:0]  result_o,
  output logic [ITER_W-1:0] iter_o,
  output logic              timeout_o,
  output logic              result_valid_o,
  input  logic              result_ready_i
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   y_prev_q, y_prev_d;
  logic [ITER_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic               timeout_q, timeout_d;
  logic               result_valid_q, result_valid_d;

  logic [WIDTH:0]     diff;
  logic [WIDTH:0]     abs_d;
  logic [ITER_W-1:0]  cnt_inc;
  logic               conv, lim_hit, lim, term, check_go;

  // One extra bit keeps y_i - y_prev exact for every pair of inputs.
  assign diff    = {y_i[WIDTH-1], y_i} - {y_prev_q[WIDTH-1], y_prev_q};
  assign abs_d   = diff[WIDTH] ? (~diff + (WIDTH+1)'(1)) : diff;
  assign conv    = (abs_d < (WIDTH+1)'(EPS));
  assign lim_hit = (cnt_q == ITER_W'(MAX_ITER - 1));
  // The counter sticks at all-ones rather than wrapping back to zero.
  assign cnt_inc = (cnt_q == {ITER_W{1'b1}}) ? cnt_q : cnt_q + ITER_W'(1);

`ifdef TERM_ITER_LIMIT_EN
  assign lim = lim_hit;
`else
  // Limit comparator is disabled; only convergence can end a run.
  assign lim = lim_hit & 1'b0;
`endif

  assign term     = conv | lim;
  // start_i wins over a coincident check_i.
  assign check_go = (state_q == RUN) && check_i && !start_i;
  // Combinational so the controller can block the next accumulator write.
  assign valid_o  = !rst && check_go && term;

  always_comb begin
    state_d        = state_q;
    y_prev_d       = y_prev_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    iter_d         = iter_q;
    timeout_d      = timeout_q;
    result_valid_d = result_valid_q;
    case (state_q)
      IDLE, RUN: begin
        if (start_i) begin
          state_d   = RUN;
          y_prev_d  = '0;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end else if (check_go) begin
          if (term) begin
            state_d        = HOLD;
            result_d       = y_i;
            iter_d         = cnt_inc;
            timeout_d      = lim & !conv;
            result_valid_d = 1'b1;
          end else begin
            y_prev_d = y_i;
            cnt_d    = cnt_inc;
          end
        end
      end
      HOLD: begin
        if (result_ready_i) begin
          state_d        = IDLE;
          result_valid_d = 1'b0;
        end
      end
      default: begin
        state_d        = IDLE;
        result_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      y_prev_q       <= '0;
      cnt_q          <= '0;
      result_q       <= '0;
      iter_q         <= '0;
      timeout_q      <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      y_prev_q       <= y_prev_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      iter_q         <= iter_d;
      timeout_q      <= timeout_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign result_o       = result_q;
  assign iter_o         = iter_q;
  assign timeout_o      = timeout_q;
  assign result_valid_o = result_valid_q;

endmodule

// File: tb/tb_approx_term_unit.sv
// Bench for approx_term_unit: directed cases plus random computations checked
// against a behavioural model; results go through a queue to a separate monitor.
module tb_approx_term_unit;
  localparam int WIDTH = 16, ITER_W = 6, EPS = 8, MAX_ITER = 32;
`ifdef TERM_ITER_LIMIT_EN
  localparam bit LIM_EN = 1'b1;
`else
  localparam bit LIM_EN = 1'b0;
`endif
  localparam int CNT_MAX = (1 << ITER_W) - 1;

  logic clk = 1'b0, rst = 1'b1;
  logic start_i = 0, check_i = 0, result_ready_i = 0;
  logic [WIDTH-1:0] y_i = '0;
  logic valid_o, timeout_o, result_valid_o;
  logic [WIDTH-1:0] result_o;
  logic [ITER_W-1:0] iter_o;

  approx_term_unit #(.WIDTH(WIDTH), .ITER_W(ITER_W), .EPS(EPS), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .check_i(check_i), .y_i(y_i),
    .valid_o(valid_o), .result_o(result_o), .iter_o(iter_o), .timeout_o(timeout_o),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i));

  always #5 clk = ~clk;

  typedef struct { int r; int it; int to; } exp_t;
  exp_t exp_q[$];

  int n_chk = 0, n_fail = 0;

  // Behavioural model: run/hold flags, previous y and number of checks so far.
  bit m_run = 0, m_hold = 0;
  int m_prev = 0, m_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // One clock cycle: drive inputs, check the Mealy stop request mid-cycle, advance the model.
  task automatic cyc(input bit s, input bit c, input int y, input bit r);
    bit conv, lim, exp_v;
    start_i = s; check_i = c; y_i = WIDTH'(y); result_ready_i = r;
    conv  = iabs(y - m_prev) < EPS;
    lim   = LIM_EN && (m_cnt + 1 == MAX_ITER);
    exp_v = !rst && m_run && c && !s && (conv || lim);
    @(negedge clk);
    chk("valid_o", int'(valid_o), int'(exp_v));
    chk("result_valid_o", int'(result_valid_o), int'(m_hold));
    @(posedge clk);
    if (rst) begin
      m_run = 0; m_hold = 0; m_prev = 0; m_cnt = 0;
    end else if (m_hold) begin
      if (r) m_hold = 0;
    end else if (s) begin
      m_run = 1; m_prev = 0; m_cnt = 0;
    end else if (m_run && c) begin
      m_cnt++;
      if (conv || lim) begin
        exp_q.push_back('{y, (m_cnt > CNT_MAX) ? CNT_MAX : m_cnt, int'(lim && !conv)});
        m_run = 0; m_hold = 1;
      end else begin
        m_prev = y;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic check_y(input int y);
    cyc(0, 1, y, 0);
    if (!m_hold) idle($urandom_range(0, 4));
  endtask

  // Accept the held result after a given number of stalled cycles.
  task automatic drain(input int stall);
    for (int i = 0; i < stall && m_hold; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 50 && m_hold; i++) cyc(0, 0, 0, 1);
    chk("drained", int'(m_hold), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_result"}, int'(result_o), 0);
    chk({tag, "_iter"}, int'(iter_o), 0);
    chk({tag, "_timeout"}, int'(timeout_o), 0);
    chk({tag, "_rvalid"}, int'(result_valid_o), 0);
    chk({tag, "_valid"}, int'(valid_o), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: pops the expected result when result_valid_o rises and checks it stays stable.
  exp_t cur;
  bit rv_seen = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (result_valid_o && !rv_seen) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
          cur = '{int'($signed(result_o)), int'(iter_o), int'(timeout_o)};
        end else begin
          cur = exp_q.pop_front();
          chk("result_o", int'($signed(result_o)), cur.r);
          chk("iter_o", int'(iter_o), cur.it);
          chk("timeout_o", int'(timeout_o), cur.to);
        end
      end else if (result_valid_o) begin
        chk("hold_result", int'($signed(result_o)), cur.r);
        chk("hold_iter", int'(iter_o), cur.it);
        chk("hold_timeout", int'(timeout_o), cur.to);
      end
      rv_seen = result_valid_o;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int y;
    // Reset, then checks in IDLE must not raise valid_o.
    rst = 1;
    cyc(0, 0, 0, 0); cyc(0, 1, 5, 0);
    check_reset_outputs("reset");
    rst = 0;
    for (int i = 0; i < 4; i++) cyc(0, 1, i, 0);
    check_reset_outputs("idle");

    // Convergence after three checks.
    cyc(1, 0, 0, 0); idle(2);
    check_y(1000); check_y(1400); check_y(1405);
    drain(1);

    // Negative deltas.
    cyc(1, 0, 0, 0); idle(1);
    check_y(-500); check_y(-300); check_y(-307);
    drain(0);

    // Extreme swing must not wrap into a false convergence.
    cyc(1, 0, 0, 0);
    check_y(32767); check_y(-32768); check_y(-32768);
    drain(0);

    // Alternating 0/100: limit stop with the macro, counter saturation without it.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 100 && !m_hold; i++) cyc(0, 1, (i % 2 == 0) ? 100 : 0, 0);
    if (!m_hold) cyc(0, 1, m_prev + 1, 0);
    drain(0);

    // Backpressure with start/check pulses that must be ignored.
    cyc(1, 0, 0, 0);
    check_y(50); check_y(52);
    for (int i = 0; i < 10; i++) cyc(i % 3 == 0, i % 3 == 1, 7777, 0);
    drain(0);
    idle(1);

    // Restart mid-run after five checks.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) check_y((i % 2 == 0) ? 100 : 0);
    cyc(1, 1, 200, 0);
    check_y(3);
    drain(0);

    // Reset while a result is held.
    cyc(1, 0, 0, 0);
    check_y(20000); check_y(20001);
    idle(2);
    rst = 1;
    cyc(0, 0, 0, 0);
    check_reset_outputs("rst_hold");
    rst = 0;

    // Random computations with back-to-back and spaced checks.
    for (int n = 0; n < 40; n++) begin
      cyc(1, 0, 0, 0);
      y = int'($urandom_range(0, 2000)) - 1000;
      for (int k = 0; k < 60 && !m_hold; k++) begin
        if (k > 0) y = (k >= 15) ? m_prev : m_prev + int'($urandom_range(0, 40)) - 20;
        cyc(0, 1, y, 0);
        if (!m_hold && ($urandom_range(0, 1) == 1)) idle($urandom_range(0, 5));
      end
      drain($urandom_range(0, 4));
      idle($urandom_range(0, 2));
    end

    idle(2);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/approx_term_unit.md
# approx_term_unit

Termination and result-handoff stage for the iterative series-approximation engine. Directly downstream of the approximation controller/datapath, it consumes the controller's per-iteration check strobe and the current accumulator value `y`. It decides when the series has converged, returns the stop request to the controller, and holds the final result on a valid/ready interface for the next pipeline stage.

## Interface
Parameters:
- `WIDTH`, 16: width of signed two's-complement accumulator `y`, same fixed-point format as the datapath.
- `ITER_W`, 6: width of the iteration counter.
- `EPS`, 8: convergence threshold in LSBs; converged when |Δy| < `EPS`.
- `MAX_ITER`, 32: iteration limit; only used with `TERM_ITER_LIMIT_EN`.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `start_i` in 1: new computation; same pulse the controller receives.
- `check_i` in 1: one-cycle termination-check strobe from the controller; `y_i` is valid in that cycle.
- `y_i` in `WIDTH`: current accumulator value from the datapath.
- `valid_o` out 1: stop request to the controller; one-cycle pulse.
- `result_o` out `WIDTH`: final `y`.
- `iter_o` out `ITER_W`: number of checks performed for this result.
- `timeout_o` out 1: result ended by the iteration limit, not by convergence.
- `result_valid_o` out 1: result available.
- `result_ready_i` in 1: downstream accepts the result.

## Operation
- States:
  - `IDLE`: waiting for `start_i`.
  - `RUN`: counting checks.
  - `HOLD`: result offered downstream.
- `IDLE`, `start_i`=1 → `RUN`. Clears `y_prev`=0, `cnt`=0 and `timeout_o`=0.
- `RUN`, `start_i`=1 → restart. Same clearing as from `IDLE`, stays in `RUN`. `start_i` has priority over `check_i`.
- `RUN`, `check_i`=1:
  - Compute `d` = `y_i` − `y_prev` at `WIDTH`+1 bits, sign-extended; no overflow is possible.
  - Compute |`d`| at `WIDTH`+1 bits unsigned.
  - `conv` = (|`d`| < `EPS`).
  - `lim` = (`cnt` == `MAX_ITER`−1); forced to 0 without the macro.
  - `term` = `conv` | `lim`.
  - `term`=0: `y_prev` ← `y_i`, `cnt` ← `cnt`+1, stay in `RUN`.
  - `term`=1: `valid_o`=1 this cycle. `result_o` ← `y_i`, `iter_o` ← `cnt`+1, `timeout_o` ← `lim`&!`conv`. Next state `HOLD`.
- `RUN`, `check_i`=0: no change.
- `HOLD`: `result_valid_o`=1; `result_o`, `iter_o` and `timeout_o` stable.
  - `result_ready_i`=1 → `IDLE`.
  - `start_i` and `check_i` are ignored in `HOLD`. Upstream must not start before the result is accepted.
- `check_i` in `IDLE` is ignored.
- Counter: `cnt` saturates at 2^`ITER_W`−1; it never wraps.
- `valid_o` is Mealy, combinational from `check_i`, `y_i` and registered state. No other output is combinational.

## Timing
- Reset values: state `IDLE`; `valid_o`=0, `result_o`=0, `iter_o`=0, `timeout_o`=0, `result_valid_o`=0; internal `y_prev`=0 and `cnt`=0.
- `valid_o` must be asserted in the same cycle as `check_i`, cycle t. The controller registers it and sees it at t+1, while it is in its add/sub phase, before the accumulator write at t+2.
  - A registered `valid_o` would let one extra term be written into `y`. This is forbidden.
- `result_valid_o` rises at t+1 and stays high until the cycle in which `result_ready_i`=1, inclusive.
- Handshake:
  - Transfer occurs on `result_valid_o` & `result_ready_i`.
  - `result_valid_o` falls the cycle after the transfer.
  - `result_ready_i` may be high permanently; minimum occupancy of `HOLD` is one cycle.
- Reset mid-operation: `rst` overrides everything at the next edge, including a pending `HOLD` result. `valid_o` is 0 while `rst`=1.
- Check-to-result latency: 1 cycle. Minimum check spacing from the controller is 5 cycles; back-to-back `check_i` must still be handled correctly.

## Configuration
- `TERM_ITER_LIMIT_EN` defined:
  - `lim` is active; at most `MAX_ITER` checks per computation.
  - `timeout_o` reports a limit stop.
- Undefined:
  - `lim`=0; termination only by convergence.
  - `timeout_o` tied to 0.
  - `MAX_ITER` is unused.

## Test plan
Assumed configuration: `WIDTH`=16, `EPS`=8, `MAX_ITER`=32.
- Reset then idle: all outputs 0; `check_i` pulses in `IDLE` → `valid_o` stays 0.
- Convergence after 3 checks:
  - Stimulus: start, then checks with `y_i`=1000, 1400, 1405.
  - `valid_o` pulses only on the third check, same cycle.
  - Next cycle: `result_o`=1405, `iter_o`=3, `timeout_o`=0, `result_valid_o`=1.
- Negative delta: checks with `y_i`=−500, −300, −307 → terminates on the third check; |Δ|=7.
  - Also: `y_i`=−32768 after `y_prev`=32767 → no overflow, no termination.
- Iteration limit, macro on: `y_i` alternating 0/100 → `valid_o` on check 32, `iter_o`=32, `timeout_o`=1.
  - Macro off: no termination after 100 checks; `cnt` saturates at 63.
- Backpressure:
  - Stimulus: `result_ready_i`=0 for 10 cycles after termination, with `start_i` and `check_i` pulsed meanwhile.
  - Result is held unchanged and the pulses are ignored.
  - `result_ready_i`=1 → `IDLE` next cycle.
- Restart/reset mid-run:
  - `start_i` during `RUN` after 5 checks → `cnt` and `y_prev` cleared; first following check with `y_i`=3 terminates, `iter_o`=1.
  - `rst` while in `HOLD` → all outputs 0 next cycle.
